// File: rtl/abcd_phase_sequencer.sv
// Purpose : round-robin arbiter that runs one a -> b[*blen] -> c -> d[*D_LEN] transaction per grant.
// Latency : gnt is combinational in IDLE; a follows one cycle later; gnt-to-done is 1+blen+1+D_LEN cycles.
// Backpressure: none downstream; requesters wait (req held) until granted; abort cuts a transaction short.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   req          level request per requester, held until its grant
//   blen         per-requester b-phase length, field i = blen[i*BW +: BW]; sampled only at grant
//   abort        synchronous abort of the transaction in flight (ignored in IDLE)
//   gnt          one-hot, single-cycle grant pulse (only in IDLE)
//   busy         high while a transaction is in flight
//   a, b, c, d   registered, mutually exclusive phase lines
//   done         single-cycle pulse during the last d cycle
//   aborted      single-cycle pulse the cycle after an abort is accepted
module abcd_phase_sequencer #(
  parameter int N_REQ = 2,
  parameter int MAX_B = 3,
  parameter int D_LEN = 2,
  localparam int BW   = $clog2(MAX_B + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*BW-1:0]   blen,
  input  logic                  abort,
  output logic [N_REQ-1:0]      gnt,
  output logic                  busy,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  done,
  output logic                  aborted
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = $clog2(D_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A,
    ST_B,
    ST_C,
    ST_D
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [BW-1:0]   blen_l, blen_nxt;
  logic [BW-1:0]   bcnt, bcnt_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic            abort_take;
  logic            last_d;

  // ---------------------------------------------------------------------------
  // Per-requester blen fields, unpacked so the winner's field can be selected
  // by index.
  // ---------------------------------------------------------------------------
  logic [BW-1:0] blen_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_blen
    assign blen_arr[g] = blen[g*BW +: BW];
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first set req at ptr+1, ptr+2, ... wrapping. ptr holds the
  // last granted requester, so it naturally has lowest priority next time.
  // ---------------------------------------------------------------------------
  logic          gr_found;
  logic [PW-1:0] gr_idx;
  logic [PW-1:0] cand;

  always_comb begin
    gr_found = 1'b0;
    gr_idx   = ptr;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % N_REQ);
      if (!gr_found && req[cand]) begin
        gr_found = 1'b1;
        gr_idx   = cand;
      end
    end
  end

  // b length of the winner, with 0 promoted to 1 and oversize values clamped.
  // Compared one bit wider so the clamp stays a real comparison even when
  // MAX_B fills the field.
  logic [BW-1:0] blen_sel;
  logic [BW:0]   blen_ext;
  logic [BW-1:0] blen_clamp;

  always_comb begin
    blen_sel = blen_arr[gr_idx];
    blen_ext = {1'b0, blen_sel};
    if (blen_sel == '0) begin
      blen_clamp = BW'(1);
    end else if (blen_ext > (BW+1)'(MAX_B)) begin
      blen_clamp = BW'(MAX_B);
    end else begin
      blen_clamp = blen_sel;
    end
  end

  // Last d cycle: done has priority over a coincident abort here.
  assign last_d = (state == ST_D) && (dcnt == DW'(D_LEN));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    blen_nxt   = blen_l;
    bcnt_nxt   = bcnt;
    dcnt_nxt   = dcnt;
    gnt        = '0;
    abort_take = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Grant is a combinational output; keep it quiet while reset is held
        // so every output reads zero during reset.
        if (rst_n && gr_found) begin
          gnt[gr_idx] = 1'b1;
          ptr_nxt     = gr_idx;
          blen_nxt    = blen_clamp;
          state_nxt   = ST_A;
        end
      end
      ST_A: begin
        state_nxt = ST_B;
        bcnt_nxt  = BW'(1);
      end
      ST_B: begin
        if (bcnt == blen_l) begin
          state_nxt = ST_C;
        end else begin
          bcnt_nxt = bcnt + BW'(1);
        end
      end
      ST_C: begin
        state_nxt = ST_D;
        dcnt_nxt  = DW'(1);
      end
      ST_D: begin
        if (last_d) begin
          state_nxt = ST_IDLE;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort drops straight back to IDLE; ptr is left on the aborted requester
    // so the others get their turn first.
    if (abort && (state != ST_IDLE) && !last_d) begin
      state_nxt  = ST_IDLE;
      abort_take = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Phase lines are decoded from the next state
  // so they come straight off flops and line up with the state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= PW'(N_REQ - 1);
      blen_l  <= '0;
      bcnt    <= '0;
      dcnt    <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
      c       <= 1'b0;
      d       <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      blen_l  <= blen_nxt;
      bcnt    <= bcnt_nxt;
      dcnt    <= dcnt_nxt;
      a       <= (state_nxt == ST_A);
      b       <= (state_nxt == ST_B);
      c       <= (state_nxt == ST_C);
      d       <= (state_nxt == ST_D);
      done    <= (state_nxt == ST_D) && (dcnt_nxt == DW'(D_LEN));
      aborted <= abort_take;
    end
  end

  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Structural invariants of the bus
  // ---------------------------------------------------------------------------
  a_phase_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({a, b, c, d}));
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));
  a_gnt_idle_only : assert property (@(posedge clk) disable iff (!rst_n)
    (|gnt) |-> !busy);
  a_done_excl_aborted : assert property (@(posedge clk) disable iff (!rst_n)
    !(done && aborted));

endmodule
